// File: rtl/rr_shi_ctrl_256.sv
// rr_shi_ctrl_256: sequencer for the 256-bit right-shift register.
// It loads WORDS words through the register's word path, then shifts the
// register out one bit at a time on a valid/ready stream.
module rr_shi_ctrl_256 #(
   parameter int unsigned WORDS  = 8,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned CNT_W  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              abort,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CNT_W-1:0]  cmd_nbits,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              bit_out,
   output logic              bit_valid,
   input  logic              bit_ready,
   output logic              done,
   output logic              busy,
   output logic              reg_we,
   output logic              reg_sel_rs,
   output logic [WORD_W-1:0] reg_din,
   input  logic              reg_lsb
);

   localparam int unsigned TOTAL_BITS = WORDS * WORD_W;
   localparam int unsigned WCNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    bits_left_q, bits_left_d;
   logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]    nbits_clamped;

   // Requests longer than the register are limited to its full width
   assign nbits_clamped = (cmd_nbits > CNT_W'(TOTAL_BITS)) ? CNT_W'(TOTAL_BITS) : cmd_nbits;

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bits_left_q <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         bits_left_q <= bits_left_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   // Next-state, counter updates and output decode
   always_comb begin
      state_d     = state_q;
      bits_left_d = bits_left_q;
      word_cnt_d  = word_cnt_q;
      cmd_ready   = 1'b0;
      word_ready  = 1'b0;
      bit_valid   = 1'b0;
      bit_out     = 1'b0;
      done        = 1'b0;
      busy        = (state_q != S_IDLE);
      reg_we      = 1'b0;
      reg_sel_rs  = 1'b0;
      reg_din     = '0;

      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && !abort) begin
               bits_left_d = nbits_clamped;
               word_cnt_d  = '0;
               state_d     = S_LOAD;
            end
         end
         S_LOAD: begin
            word_ready = !abort;
            reg_din    = word_in;
            if (word_valid && word_ready) begin
               reg_we     = 1'b1;
               word_cnt_d = word_cnt_q + 1'b1;
               if (word_cnt_q == WCNT_W'(WORDS - 1)) begin
                  state_d = (bits_left_q != '0) ? S_SHIFT : S_DONE;
               end
            end
         end
         S_SHIFT: begin
            bit_valid  = !abort;
            bit_out    = reg_lsb;
            reg_sel_rs = 1'b1;
            if (bit_valid && bit_ready) begin
               reg_we      = 1'b1;
               bits_left_d = bits_left_q - 1'b1;
               if (bits_left_q == CNT_W'(1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            done    = !abort;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Cancel wins over any handshake; register contents are untouched
      if (abort) begin
         state_d = S_IDLE;
      end
   end

endmodule

// File: tb/tb_rr_shi_ctrl_256.sv
// Bench for rr_shi_ctrl_256 with a behavioural 256-bit shift register model.
module tb_rr_shi_ctrl_256;

   localparam int unsigned WORDS  = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 9;
   localparam int unsigned NBITS  = WORDS * WORD_W;

   logic              clk        = 1'b0;
   logic              rst_n      = 1'b0;
   logic              abort      = 1'b0;
   logic              cmd_valid  = 1'b0;
   logic              cmd_ready;
   logic [CNT_W-1:0]  cmd_nbits  = '0;
   logic [WORD_W-1:0] word_in    = '0;
   logic              word_valid = 1'b0;
   logic              word_ready;
   logic              bit_out;
   logic              bit_valid;
   logic              bit_ready  = 1'b0;
   logic              done;
   logic              busy;
   logic              reg_we;
   logic              reg_sel_rs;
   logic [WORD_W-1:0] reg_din;
   logic              reg_lsb;

   logic [NBITS-1:0]  shreg = '0;
   logic [WORD_W-1:0] words [WORDS];
   bit                exp_q [$];
   int                tests = 0;
   int                fails = 0;

   rr_shi_ctrl_256 #(.WORDS(WORDS), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .abort      (abort),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_nbits  (cmd_nbits),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .bit_ready  (bit_ready),
      .done       (done),
      .busy       (busy),
      .reg_we     (reg_we),
      .reg_sel_rs (reg_sel_rs),
      .reg_din    (reg_din),
      .reg_lsb    (reg_lsb)
   );

   always #5 clk = ~clk;

   // Shift register model: word load enters at the top, so the first word ends low
   always @(posedge clk) begin
      if (reg_we) begin
         if (reg_sel_rs) shreg <= {1'b0, shreg[NBITS-1:1]};
         else            shreg <= {reg_din, shreg[NBITS-1:WORD_W]};
      end
   end
   assign reg_lsb = shreg[0];

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check1({tag, "_cmd_ready"},  cmd_ready,  1'b1);
      check1({tag, "_busy"},       busy,       1'b0);
      check1({tag, "_reg_we"},     reg_we,     1'b0);
      check1({tag, "_word_ready"}, word_ready, 1'b0);
      check1({tag, "_bit_valid"},  bit_valid,  1'b0);
      check1({tag, "_bit_out"},    bit_out,    1'b0);
      check1({tag, "_done"},       done,       1'b0);
      check1({tag, "_sel_rs"},     reg_sel_rs, 1'b0);
      check32({tag, "_reg_din"},   reg_din,    32'h0);
   endtask

   // kill_kind: 0 none, 1 reset after kill_at bits, 2 abort after kill_at words
   task automatic run_txn(input int n, input int mode, input int kill_kind, input int kill_at);
      int nc        = (n > int'(NBITS)) ? int'(NBITS) : n;
      int cyc       = 1;
      int wi        = 0;
      int bits_acc  = 0;
      int valid_cyc = 0;
      int load_we   = 0;
      int shift_we  = 0;
      int done_cnt  = 0;
      int done_cyc  = 0;
      int late_done = 0;
      bit fin       = 1'b0;
      bit prev_stall = 1'b0;
      logic prev_bit = 1'b0;
      bit e;
      bit hs_w, hs_b;

      exp_q.delete();
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_nbits = CNT_W'(n);
      @(negedge clk);
      check1("cmd_ready_idle", cmd_ready, 1'b1);
      check1("busy_idle", busy, 1'b0);
      for (int i = 0; i < nc; i++) exp_q.push_back(words[i / WORD_W][i % WORD_W]);

      while (!fin && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         word_valid = (wi < int'(WORDS));
         word_in    = (wi < int'(WORDS)) ? words[wi] : '0;
         bit_ready  = (mode == 0) ? 1'b1 : cyc[0];
         if (kill_kind == 2 && wi == kill_at) abort = 1'b1;
         @(negedge clk);
         hs_w = word_valid && word_ready;
         hs_b = bit_valid && bit_ready;
         if (abort) begin
            check1("abort_reg_we", reg_we, 1'b0);
            check1("abort_word_ready", word_ready, 1'b0);
            check1("abort_done", done, 1'b0);
            @(posedge clk); #1;
            abort      = 1'b0;
            cmd_valid  = 1'b0;
            word_valid = 1'b0;
            @(negedge clk);
            check1("abort_idle_busy", busy, 1'b0);
            check1("abort_idle_cmd_ready", cmd_ready, 1'b1);
            repeat (12) begin
               @(negedge clk);
               if (done) late_done++;
            end
            check32("abort_no_done", late_done, 0);
            fin = 1'b1;
         end else if (kill_kind == 1 && bits_acc == kill_at && bit_valid) begin
            #2 rst_n = 1'b0;
            #1;
            check_reset_outputs("midshift_rst");
            cmd_valid  = 1'b0;
            word_valid = 1'b0;
            bit_ready  = 1'b0;
            @(negedge clk);
            check1("midshift_rst_no_done", done, 1'b0);
            rst_n = 1'b1;
            fin = 1'b1;
         end else begin
            check1("busy_active", busy, 1'b1);
            check1("cmd_ignored_busy", cmd_ready, 1'b0);
            if (hs_w) begin
               check1("load_we", reg_we, 1'b1);
               check1("load_sel", reg_sel_rs, 1'b0);
               check32("load_din", reg_din, words[wi]);
            end
            if (hs_b) begin
               if (exp_q.size() == 0) begin
                  check32("extra_bit", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check1("bit_value", bit_out, e);
               end
               check1("shift_we", reg_we, 1'b1);
               check1("shift_sel", reg_sel_rs, 1'b1);
            end
            if (bit_valid && !bit_ready) check1("stall_no_we", reg_we, 1'b0);
            if (prev_stall) begin
               check1("stall_valid_hold", bit_valid, 1'b1);
               check1("stall_bit_hold", bit_out, prev_bit);
            end
            if (bit_valid) valid_cyc++;
            if (reg_we && reg_sel_rs)  shift_we++;
            if (reg_we && !reg_sel_rs) load_we++;
            if (done) begin
               done_cnt++;
               done_cyc  = cyc;
               cmd_valid = 1'b0;
               fin       = 1'b1;
            end
            prev_stall = bit_valid && !bit_ready;
            prev_bit   = bit_out;
            if (hs_w) wi++;
            if (hs_b) bits_acc++;
         end
      end
      check1("txn_timeout", fin, 1'b1);
      cmd_valid  = 1'b0;
      word_valid = 1'b0;

      if (kill_kind == 0) begin
         check32("done_count", done_cnt, 1);
         check32("bits_consumed", bits_acc, nc);
         check32("load_we_count", load_we, WORDS);
         check32("shift_we_count", shift_we, nc);
         check32("queue_empty", exp_q.size(), 0);
         if (mode == 0) begin
            check32("done_latency", done_cyc, 1 + WORDS + nc + 1);
            check32("valid_cycles", valid_cyc, nc);
         end
         @(negedge clk);
         check1("post_done_pulse", done, 1'b0);
         check1("post_done_busy", busy, 1'b0);
         check1("post_done_cmd_ready", cmd_ready, 1'b1);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Reset arriving mid-shift, then a fresh command
      for (int i = 0; i < int'(WORDS); i++) words[i] = $urandom;
      run_txn(100, 0, 1, 40);
      words[0] = 32'h0000_0005;
      for (int i = 1; i < int'(WORDS); i++) words[i] = '0;
      run_txn(4, 0, 0, 0);

      // Full width with a toggling consumer
      for (int i = 0; i < int'(WORDS); i++) words[i] = 32'hFFFF_FFFF;
      run_txn(256, 1, 0, 0);

      // Zero-length request
      for (int i = 0; i < int'(WORDS); i++) words[i] = $urandom;
      run_txn(0, 0, 0, 0);

      // Oversized request is clamped
      words[0] = 32'h0000_0001;
      for (int i = 1; i < int'(WORDS); i++) words[i] = '0;
      run_txn(300, 0, 0, 0);

      // Random pattern, odd length, stalling consumer
      for (int i = 0; i < int'(WORDS); i++) words[i] = $urandom;
      run_txn(77, 1, 0, 0);

      // Abort during load
      run_txn(8, 0, 2, 3);

      // Normal command after abort
      for (int i = 0; i < int'(WORDS); i++) words[i] = $urandom;
      run_txn(33, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rr_shi_ctrl_256.md
# rr_shi_ctrl_256

Sequencer for the 256-bit right-shift register in the modular-division datapath. It accepts a command, streams eight 32-bit words into the register through its word-load path, then shifts it right one bit at a time under consumer back-pressure. It presents each least-significant bit on a valid/ready stream and pulses `done` when the requested bit count has been consumed. It drives the register's `we`, `sel_rs` and `regin` inputs directly and observes its bit 0.

## Interface
- `WORDS`, 8: words per load; the register width is WORDS×WORD_W.
- `WORD_W`, 32: load word width.
- `CNT_W`, 9: bit-count width; must hold WORDS×WORD_W.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `abort` in 1: synchronous cancel; has priority over every handshake.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_nbits` in CNT_W: number of bits to shift out (0..256; values above 256 are clamped to 256).
- `word_in` in WORD_W / `word_valid` in 1 / `word_ready` out 1: load-word stream, least-significant word first.
- `bit_out` out 1 / `bit_valid` out 1 / `bit_ready` in 1: output bit stream, LSB first.
- `done` out 1: one-cycle pulse after the last bit is accepted.
- `busy` out 1: high in any state other than IDLE.
- `reg_we` out 1 / `reg_sel_rs` out 1 / `reg_din` out WORD_W: to the shift register (`sel_rs` 0 = 32-bit word load, 1 = 1-bit right shift).
- `reg_lsb` in 1: bit 0 of the register's 256-bit output.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs are combinational decodes of registered state, the counters and the current inputs.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&!`abort`: latch `min(cmd_nbits,256)` into `bits_left`, clear `word_cnt`, go to LOAD.
- LOAD:
  - `word_ready`=!`abort`, `reg_din`=`word_in`, `reg_sel_rs`=0, `reg_we`=`word_valid`&&`word_ready`.
  - Each accepted word increments `word_cnt`.
  - On the accept with `word_cnt`==WORDS-1, go to SHIFT if `bits_left`≠0, else go to DONE.
  - The word accepted first ends up in the low 32 bits of the register.
- SHIFT:
  - `bit_valid`=!`abort`, `bit_out`=`reg_lsb`, `reg_sel_rs`=1, `reg_we`=`bit_valid`&&`bit_ready`.
  - Each accepted bit shifts the register right by one (zero fill at the top) and decrements `bits_left`.
  - The accept at `bits_left`==1 goes to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `cmd_ready`=0 in this state.
- `abort`=1 in any state:
  - Next state is IDLE.
  - `reg_we`, `word_ready`, `bit_valid` and `done` are forced to 0 in that cycle; no transfer is counted.
  - Register contents are left as they are.
- `reg_we`=0 whenever no handshake completes, so the register holds its contents while stalled.
- `cmd_valid` outside IDLE is ignored; it is not queued.

## Timing
- Reset (`rst_n` low, at any time, including mid-load or mid-shift):
  - State goes to IDLE immediately; counters clear.
  - Outputs: `cmd_ready`=1; `word_ready`, `bit_valid`, `bit_out`, `done`, `busy`, `reg_we`, `reg_sel_rs` all 0; `reg_din`=0.
- Command accepted at edge T: LOAD from T+1.
- The load takes ≥WORDS cycles (one word per cycle at most).
- The first bit is valid in the cycle after the final word is accepted, because `reg_lsb` reflects the new register contents then.
- A bit accepted at edge E: the next bit appears on `bit_out` in cycle E+1. Throughput is 1 bit/cycle with `bit_ready` held high.
- Minimum command-to-`done` latency: 1 + 8 + n + 1 cycles (n = clamped nbits). The `done` cycle is followed by IDLE; the next command is accepted ≥1 cycle after `done`.
- `bit_valid` stays high while stalled; `bit_out` is stable while stalled.

## Test plan
- Reset mid-SHIFT (n=100, 40 bits taken) -> immediate IDLE, `cmd_ready`=1, no `done`, `reg_we`=0. A new command afterwards behaves normally.
- Command n=4; words 0x00000005 then 7×0x00000000, `bit_ready`=1 -> bits 1,0,1,0; exactly 8 load `reg_we` pulses with `reg_sel_rs`=0 and 4 shift pulses with `reg_sel_rs`=1; `done` 14 cycles after command accept.
- Command n=256; words 0xFFFFFFFF×8; `bit_ready` toggling 1/0 -> 256 ones, `bit_out`/`bit_valid` held through stalls, no `reg_we` in stall cycles, single `done`.
- Command n=0 -> 8 words loaded, no `bit_valid`, `done` the cycle after the 8th word.
- Command n=300 -> clamped: exactly 256 bits delivered, the last 224 being the zero fill from 8 loaded words? no: with words 0x00000001, 7×0 -> bit0=1, then 255 zeros, then `done`.
- `abort` during LOAD after 3 words with `word_valid`=1 -> no `reg_we` that cycle, IDLE next cycle, no `done`; `cmd_valid` while busy is ignored throughout.
